multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS-subset datapath (add, addi, lw, sw, bgtz, j).

---
 rtl/multicycle_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for a MIPS-subset datapath
// (add, addi, lw, sw, bgtz, j).
// Moore outputs are decoded from the current state. IRWrite/PCWrite in FETCH
// and instr_done in MEMWR are additionally gated by mem_ready.
// Memory accesses use a req/ready handshake guarded by a wait-cycle timeout.
module multicycle_ctrl #(
   parameter int unsigned MEM_WAIT_MAX = 16,
   parameter logic [2:0]  ALU_ADD      = 3'b111,
   parameter logic [2:0]  ALU_SUB      = 3'b110,
   parameter logic [2:0]  ALU_PASS     = 3'b101
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic [1:0] PCSource,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       instr_done,
   output logic       illegal_op,
   output logic       mem_err,
   output logic [3:0] state
);

   localparam logic [3:0] S_RESET    = 4'd0;
   localparam logic [3:0] S_FETCH    = 4'd1;
   localparam logic [3:0] S_DECODE   = 4'd2;
   localparam logic [3:0] S_RTYPE_EX = 4'd3;
   localparam logic [3:0] S_RTYPE_WB = 4'd4;
   localparam logic [3:0] S_ADDI_EX  = 4'd5;
   localparam logic [3:0] S_ADDI_WB  = 4'd6;
   localparam logic [3:0] S_MEMADR   = 4'd7;
   localparam logic [3:0] S_MEMRD    = 4'd8;
   localparam logic [3:0] S_MEMWB    = 4'd9;
   localparam logic [3:0] S_MEMWR    = 4'd10;
   localparam logic [3:0] S_BRANCH   = 4'd11;
   localparam logic [3:0] S_JUMP     = 4'd12;
   localparam logic [3:0] S_ILLEGAL  = 4'd13;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BGTZ  = 6'b000111;
   localparam logic [5:0] OP_J     = 6'b000010;

   // The counter only has to reach MEM_WAIT_MAX-1
   localparam int unsigned    WCW       = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_WAIT_MAX - 1);

   logic [3:0]     state_q, state_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic           mem_phase;
   logic           timeout;

   // Wait counter: zero on entry to any memory state, counts stalled cycles,
   // and flags a timeout when the last allowed cycle also stalls.
   always_comb begin
      mem_phase  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
      timeout    = mem_phase && !mem_ready && (wait_cnt_q == WAIT_LAST);
      wait_cnt_d = '0;
      if (mem_phase && !mem_ready && !timeout) begin
         wait_cnt_d = wait_cnt_q + WCW'(1);
      end
   end

   // Next-state logic; mem_ready takes priority over a same-cycle timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET:    state_d = S_FETCH;
         S_FETCH: begin
            if (mem_ready)    state_d = S_DECODE;
            else if (timeout) state_d = S_FETCH;   // retry the same PC
         end
         S_DECODE: begin
            case (op)
               OP_RTYPE:     state_d = S_RTYPE_EX;
               OP_ADDI:      state_d = S_ADDI_EX;
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BGTZ:      state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_RTYPE_EX: state_d = S_RTYPE_WB;
         S_ADDI_EX:  state_d = S_ADDI_WB;
         S_MEMADR: begin
            if (op == OP_LW)      state_d = S_MEMRD;
            else if (op == OP_SW) state_d = S_MEMWR;
            else                  state_d = S_ILLEGAL;  // opcode changed under us
         end
         S_MEMRD: begin
            if (mem_ready)    state_d = S_MEMWB;
            else if (timeout) state_d = S_FETCH;
         end
         S_MEMWR: begin
            if (mem_ready || timeout) state_d = S_FETCH;
         end
         S_RTYPE_WB, S_ADDI_WB, S_MEMWB,
         S_BRANCH, S_JUMP, S_ILLEGAL: state_d = S_FETCH;
         default:    state_d = S_RESET;    // unused codes recover through RESET
      endcase
   end

   // State and wait-counter registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_RESET;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Datapath control decode: everything defaults to 0, ALU defaults to add
   always_comb begin
      mem_req     = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSource    = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUControl  = ALU_ADD;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      mem_err     = timeout;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            MemRead = 1'b1;
            ALUSrcB = 2'b01;            // PC + 4
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;            // precompute branch target
         end
         S_RTYPE_EX: begin
            ALUSrcA = 1'b1;
         end
         S_RTYPE_WB: begin
            RegDst     = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_ADDI_EX, S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_ADDI_WB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            MemtoReg   = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            mem_req    = 1'b1;
            MemWrite   = 1'b1;
            IorD       = 1'b1;
            instr_done = mem_ready;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUControl  = ALU_SUB;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            instr_done  = 1'b1;
         end
         S_JUMP: begin
            ALUControl = ALU_PASS;
            PCWrite    = 1'b1;
            PCSource   = 2'b10;
            instr_done = 1'b1;
         end
         S_ILLEGAL: begin
            illegal_op = 1'b1;
         end
         default: ;
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized transaction-level bench for multicycle_ctrl.
// Each instruction is expanded by a reference model into the expected per-cycle
// state trace plus per-instruction strobe totals, then replayed on the DUT.
module tb_multicycle_ctrl;

   localparam int MAX = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] op = 6'd0;
   logic       mem_ready = 1'b0;
   logic       mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
   logic [1:0] PCSource, ALUSrcB;
   logic       ALUSrcA, RegDst, MemtoReg, RegWrite, instr_done, illegal_op, mem_err;
   logic [2:0] ALUControl;
   logic [3:0] state;

   int checks = 0;
   int passes = 0;

   // expected per-cycle trace of the current instruction
   int exp_st[$];
   bit exp_rdy[$];
   bit exp_err[$];

   multicycle_ctrl #(.MEM_WAIT_MAX(MAX)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
      .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .instr_done(instr_done), .illegal_op(illegal_op),
      .mem_err(mem_err), .state(state)
   );

   always #5 clk = ~clk;

   function automatic void add_cyc(int s, bit r, bit e);
      exp_st.push_back(s);
      exp_rdy.push_back(r);
      exp_err.push_back(e);
   endfunction

   function automatic bit is_known(logic [5:0] o);
      return (o == 6'd0) || (o == 6'd8) || (o == 6'd35) || (o == 6'd43) ||
             (o == 6'd7) || (o == 6'd2);
   endfunction

   // Model one instruction: fw/dw = stall cycles on fetch/data access (>=MAX means timeout).
   task automatic run_txn(input logic [5:0] o, input int fw, input int dw, input bit noisy,
                          input string tag);
      bit ft, dt, is_r, is_i, is_lw, is_sw, is_b, is_j, is_ill;
      int e_done, e_irw, e_pcw, e_regw, e_memw, e_ill, e_err, e_pcwc;
      int n_done, n_irw, n_pcw, n_regw, n_memw, n_ill, n_err, n_pcwc;
      logic [3:0] es;
      bit em, nr;
      exp_st.delete(); exp_rdy.delete(); exp_err.delete();
      ft = (fw >= MAX);
      dt = (dw >= MAX);
      is_r = (o == 6'd0); is_i = (o == 6'd8); is_lw = (o == 6'd35); is_sw = (o == 6'd43);
      is_b = (o == 6'd7); is_j = (o == 6'd2); is_ill = !is_known(o);
      // fetch phase
      for (int k = 0; k < (ft ? MAX : fw); k++) add_cyc(1, 1'b0, ft && (k == MAX - 1));
      if (!ft) begin
         add_cyc(1, 1'b1, 1'b0);
         nr = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
         add_cyc(2, nr, 1'b0);
         if (is_r) begin add_cyc(3, nr, 1'b0); add_cyc(4, nr, 1'b0); end
         else if (is_i) begin add_cyc(5, nr, 1'b0); add_cyc(6, nr, 1'b0); end
         else if (is_lw || is_sw) begin
            add_cyc(7, nr, 1'b0);
            for (int k = 0; k < (dt ? MAX : dw); k++)
               add_cyc(is_lw ? 8 : 10, 1'b0, dt && (k == MAX - 1));
            if (!dt) begin
               add_cyc(is_lw ? 8 : 10, 1'b1, 1'b0);
               if (is_lw) add_cyc(9, nr, 1'b0);
            end
         end
         else if (is_b) add_cyc(11, nr, 1'b0);
         else if (is_j) add_cyc(12, nr, 1'b0);
         else add_cyc(13, nr, 1'b0);
      end
      e_irw  = ft ? 0 : 1;
      e_pcw  = ft ? 0 : (is_j ? 2 : 1);
      e_done = (!ft && !is_ill && !((is_lw || is_sw) && dt)) ? 1 : 0;
      e_regw = (!ft && (is_r || is_i || (is_lw && !dt))) ? 1 : 0;
      e_memw = (!ft && is_sw) ? (dt ? MAX : dw + 1) : 0;
      e_ill  = (!ft && is_ill) ? 1 : 0;
      e_err  = (ft || ((is_lw || is_sw) && dt)) ? 1 : 0;
      e_pcwc = (!ft && is_b) ? 1 : 0;
      n_done = 0; n_irw = 0; n_pcw = 0; n_regw = 0; n_memw = 0; n_ill = 0; n_err = 0; n_pcwc = 0;
      op = o;
      for (int i = 0; i < exp_st.size(); i++) begin
         mem_ready = exp_rdy[i];
         @(negedge clk);
         es = 4'(exp_st[i]);
         em = (es == 4'd1) || (es == 4'd8) || (es == 4'd10);
         checks++;
         if (state !== es) $display("FAIL %s cyc%0d state: got %0d want %0d", tag, i, state, es);
         else passes++;
         checks++;
         if ({mem_req, IorD} !== {em, em && (es != 4'd1)})
            $display("FAIL %s cyc%0d mem_req/IorD: got %b%b want %b%b", tag, i, mem_req, IorD,
                     em, em && (es != 4'd1));
         else passes++;
         checks++;
         if (mem_err !== exp_err[i])
            $display("FAIL %s cyc%0d mem_err: got %b want %b", tag, i, mem_err, exp_err[i]);
         else passes++;
         if (es == 4'd11) begin
            checks++;
            if ({ALUControl, PCSource, PCWriteCond, ALUSrcA} !== 7'b110_01_1_1)
               $display("FAIL %s branch ctl: got alu=%b pcsrc=%b", tag, ALUControl, PCSource);
            else passes++;
         end
         if (es == 4'd12) begin
            checks++;
            if ({ALUControl, PCSource, PCWrite} !== 6'b101_10_1)
               $display("FAIL %s jump ctl: got alu=%b pcsrc=%b pcw=%b", tag, ALUControl, PCSource, PCWrite);
            else passes++;
         end
         if (es == 4'd9 || es == 4'd4 || es == 4'd6) begin
            checks++;
            if ({MemtoReg, RegDst} !== {es == 4'd9, es == 4'd4})
               $display("FAIL %s wb ctl: got memtoreg=%b regdst=%b", tag, MemtoReg, RegDst);
            else passes++;
         end
         if (instr_done === 1'b1) n_done++;
         if (IRWrite === 1'b1) n_irw++;
         if (PCWrite === 1'b1) n_pcw++;
         if (RegWrite === 1'b1) n_regw++;
         if (MemWrite === 1'b1) n_memw++;
         if (illegal_op === 1'b1) n_ill++;
         if (mem_err === 1'b1) n_err++;
         if (PCWriteCond === 1'b1) n_pcwc++;
         @(posedge clk); #1;
      end
      checks++;
      if ({n_done, n_irw, n_pcw, n_regw} !== {e_done, e_irw, e_pcw, e_regw})
         $display("FAIL %s strobes done/irw/pcw/regw: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                  tag, n_done, n_irw, n_pcw, n_regw, e_done, e_irw, e_pcw, e_regw);
      else passes++;
      checks++;
      if ({n_memw, n_ill, n_err, n_pcwc} !== {e_memw, e_ill, e_err, e_pcwc})
         $display("FAIL %s strobes memw/ill/err/pcwc: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                  tag, n_memw, n_ill, n_err, n_pcwc, e_memw, e_ill, e_err, e_pcwc);
      else passes++;
      $display("txn %s op=%b fw=%0d dw=%0d cycles=%0d", tag, o, fw, dw, exp_st.size());
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_ready = 1'b1; op = 6'd0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({state, ALUControl} !== {4'd0, 3'b111} ||
          {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, PCSource, ALUSrcA,
           ALUSrcB, RegDst, MemtoReg, RegWrite, instr_done, illegal_op, mem_err} !== 19'd0)
         $display("FAIL reset outputs: got state=%0d alu=%b req=%b irw=%b", state, ALUControl, mem_req, IRWrite);
      else passes++;
      rst_n = 1'b1; mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (state !== 4'd0) $display("FAIL reset hold: got %0d want 0", state);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if ({state, mem_req, IorD, MemRead} !== {4'd1, 1'b1, 1'b0, 1'b1})
         $display("FAIL reset exit: got state=%0d req=%b iord=%b", state, mem_req, IorD);
      else passes++;
      $display("txn reset done");
   endtask

   task automatic test_add();
      run_txn(6'b000000, 0, 0, 1'b0, "add");
   endtask

   task automatic test_lw_wait();
      run_txn(6'b100011, 0, 3, 1'b1, "lw_wait3");
   endtask

   task automatic test_sw_bgtz_j();
      run_txn(6'b101011, 0, 0, 1'b1, "sw");
      run_txn(6'b000111, 1, 0, 1'b1, "bgtz");
      run_txn(6'b000010, 0, 0, 1'b1, "j");
      run_txn(6'b001000, 2, 0, 1'b1, "addi");
   endtask

   task automatic test_illegal();
      run_txn(6'b111111, 0, 0, 1'b1, "illegal");
   endtask

   task automatic test_timeouts();
      run_txn(6'b000000, MAX, 0, 1'b1, "fetch_timeout");
      run_txn(6'b000000, 0, 0, 1'b1, "fetch_retry");
      run_txn(6'b001000, MAX - 1, 0, 1'b1, "fetch_ready_last");
      run_txn(6'b100011, 0, MAX, 1'b1, "lw_timeout");
      run_txn(6'b101011, 0, MAX, 1'b1, "sw_timeout");
      run_txn(6'b101011, 0, MAX - 1, 1'b1, "sw_ready_last");
   endtask

   task automatic test_reset_mid_memwr();
      op = 6'b101011;
      mem_ready = 1'b1;
      @(posedge clk); #1;            // FETCH -> DECODE
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);     // MEMADR, MEMWR
      #1;
      @(negedge clk);
      checks++;
      if ({state, MemWrite} !== {4'd10, 1'b1})
         $display("FAIL midrst pre: got state=%0d memwrite=%b", state, MemWrite);
      else passes++;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({state, MemWrite, mem_req, instr_done} !== {4'd0, 3'b000})
         $display("FAIL midrst post: got state=%0d memwrite=%b done=%b", state, MemWrite, instr_done);
      else passes++;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (state !== 4'd1) $display("FAIL midrst refetch: got %0d want 1", state);
      else passes++;
      $display("txn reset_mid_memwr done");
   endtask

   task automatic test_random(input int n);
      logic [5:0] o;
      int fw, dw;
      for (int t = 0; t < n; t++) begin
         case ($urandom_range(0, 6))
            0: o = 6'd0;
            1: o = 6'd8;
            2: o = 6'd35;
            3: o = 6'd43;
            4: o = 6'd7;
            5: o = 6'd2;
            default: begin
               o = 6'($urandom_range(0, 63));
               while (is_known(o)) o = 6'($urandom_range(0, 63));
            end
         endcase
         fw = ($urandom_range(0, 9) == 0) ? MAX : int'($urandom_range(0, 3));
         dw = ($urandom_range(0, 7) == 0) ? MAX : int'($urandom_range(0, 4));
         run_txn(o, fw, dw, 1'b1, "rand");
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw_wait();
      test_sw_bgtz_j();
      test_illegal();
      test_timeouts();
      test_reset_mid_memwr();
      test_random(60);
      @(negedge clk);
      checks++;
      if (state !== 4'd1) $display("FAIL final state: got %0d want 1", state);
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
